// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//
// Purpose : Shared sizing helpers for the pipelined N-bit adder. The carry
//           chain of an N-bit add is cut into STAGES chunks. Every chunk is
//           ceil(N/STAGES) bits wide except the last one, which takes the
//           remainder.
//
// Contents:
//   MAX_STAGES  - upper limit on the number of pipeline stages
//   calc_chunk  - ceil(n/stages), the width of every chunk except the last
//   last_chunk  - width of the final chunk (must come out > 0)
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int MAX_STAGES = 64;

    // Width of a regular chunk. Returns 0 for a non-positive stage count so
    // that the parameter check in the top can report it cleanly.
    function automatic int calc_chunk(input int n, input int stages);
        if (stages < 1) begin
            return 0;
        end else begin
            return (n + stages - 1) / stages;
        end
    endfunction

    // Width of the final chunk. It holds whatever the regular chunks leave.
    function automatic int last_chunk(input int n, input int stages);
        return n - (stages - 1) * calc_chunk(n, stages);
    endfunction

endpackage : adder_pkg

// File: rtl/adder_pipe_stage.sv
// -----------------------------------------------------------------------------
// adder_pipe_stage
//
// Purpose : One carry chunk of the pipelined adder. The stage adds operand
//           bits [LO_W +: CHUNK_W] and the incoming carry. On en_i it
//           registers four things:
//             - the result bits merged into the lower sum bits computed so far,
//             - the chunk carry-out,
//             - the operands with the consumed bits cleared, so only the
//               upper bits still to be added remain,
//             - the valid bit.
//           The operand MSB (the sign bit) is never cleared. It rides through
//           to the end of the pipe for the optional signed-overflow flag.
//           Synthesis trims it when nothing uses it.
//
// Parameters:
//   W       - full operand width (must equal LO_W + CHUNK_W + HI_W)
//   LO_W    - sum bits already produced by earlier stages
//   CHUNK_W - bits added in this stage (>= 1)
//   HI_W    - operand bits left for later stages
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en_i            global pipeline advance; the stage holds when low
//   valid_i/valid_o stage occupancy in / registered out
//   carry_i/carry_o carry from the previous stage / registered chunk carry
//   a_i, b_i        carried operands (consumed bits already zero)
//   a_o, b_o        registered operands with this chunk also cleared
//   sum_i/sum_o     lower sum bits in / registered with this chunk merged
// -----------------------------------------------------------------------------
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int W       = 2,
    parameter int LO_W    = 0,
    parameter int CHUNK_W = 1,
    parameter int HI_W    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic         carry_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] sum_i,
    output logic         valid_o,
    output logic         carry_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] sum_o
);

    if (CHUNK_W < 1 || LO_W < 0 || HI_W < 0 || (LO_W + CHUNK_W + HI_W) != W) begin : g_param_check
        $error("adder_pipe_stage: inconsistent chunk geometry");
    end

    logic [CHUNK_W:0] part_s;
    logic [W-1:0]     keep_s;

    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic [W-1:0]     a_d, a_q;
    logic [W-1:0]     b_d, b_q;
    logic [W-1:0]     sum_d, sum_q;

    // Chunk add and next-state values for the stage registers.
    always_comb begin
        part_s = {1'b0, a_i[LO_W +: CHUNK_W]}
               + {1'b0, b_i[LO_W +: CHUNK_W]}
               + {{CHUNK_W{1'b0}}, carry_i};

        // Keep the operand bits above this chunk and the sign bit.
        keep_s = '0;
        for (int i = 0; i < W; i++) begin
            keep_s[i] = (i >= LO_W + CHUNK_W) || (i == W - 1);
        end

        valid_d = valid_i;
        carry_d = part_s[CHUNK_W];
        a_d     = a_i & keep_s;
        b_d     = b_i & keep_s;
        // sum_i is zero from LO_W upwards, so OR-ing the chunk in places it.
        sum_d   = sum_i | (W'(part_s[CHUNK_W-1:0]) << LO_W);
    end

    // Stage registers: cleared on reset, advance only when the pipe is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;

endmodule : adder_pipe_stage

// File: rtl/adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbit
//
// Purpose : Pipelined N-bit unsigned adder with carry-in and carry-out.
//           The carry chain is split into STAGES register-separated chunks.
//           Valid/ready handshakes sit on both sides.
//
//           The pipeline uses a single global enable:
//             en = !out_valid || out_ready
//           Every stage advances together when en is high, bubbles included,
//           and every stage holds when en is low. in_ready equals en, so
//           in_ready depends on out_ready and the output valid register and
//           never on in_valid. Latency is STAGES cycles and throughput is one
//           result per cycle.
//
// Optional feature (macro ADDER_PIPE_OVF_EN):
//   Adds output ovf, the two's-complement overflow of the N-bit signed add,
//   taken from the sign bits carried through the pipe and the registered
//   sum MSB. Without the macro the port and its logic are absent.
//
// Parameters:
//   N      - operand width (>= 1)
//   STAGES - pipeline stages / carry chunks (1..N, <= MAX_STAGES, last chunk > 0)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin valid this cycle
//   in_ready   block accepts input this cycle
//   a, b       unsigned operands
//   cin        carry-in
//   out_valid  sum valid
//   out_ready  consumer accepts sum
//   sum        a+b+cin, sum[N] is the carry-out
//   ovf        (ADDER_PIPE_OVF_EN only) signed overflow, meaningful with out_valid
// -----------------------------------------------------------------------------
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int N      = 10,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CHUNK = calc_chunk(N, STAGES);
    localparam int LAST  = last_chunk(N, STAGES);

    if (N < 1 || STAGES < 1 || STAGES > N || STAGES > MAX_STAGES || LAST < 1) begin : g_param_check
        $error("adder_pipe_nbit: illegal N/STAGES combination");
    end

    // Index k is the input side of stage k. Index STAGES is the pipe output.
    logic         valid_p [0:STAGES];
    logic         carry_p [0:STAGES];
    logic [N-1:0] a_p     [0:STAGES];
    logic [N-1:0] b_p     [0:STAGES];
    logic [N-1:0] sum_p   [0:STAGES];

    logic         en_s;

    assign en_s     = !valid_p[STAGES] || out_ready;
    assign in_ready = en_s;

    assign valid_p[0] = in_valid;
    assign carry_p[0] = cin;
    assign a_p[0]     = a;
    assign b_p[0]     = b;
    assign sum_p[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_W = k * CHUNK;
        localparam int CW   = (k == STAGES - 1) ? LAST : CHUNK;
        localparam int HI_W = N - LO_W - CW;

        adder_pipe_stage #(
            .W       (N),
            .LO_W    (LO_W),
            .CHUNK_W (CW),
            .HI_W    (HI_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en_s),
            .valid_i (valid_p[k]),
            .carry_i (carry_p[k]),
            .a_i     (a_p[k]),
            .b_i     (b_p[k]),
            .sum_i   (sum_p[k]),
            .valid_o (valid_p[k+1]),
            .carry_o (carry_p[k+1]),
            .a_o     (a_p[k+1]),
            .b_o     (b_p[k+1]),
            .sum_o   (sum_p[k+1])
        );
    end

    assign out_valid = valid_p[STAGES];
    assign sum       = {carry_p[STAGES], sum_p[STAGES]};

`ifdef ADDER_PIPE_OVF_EN
    // Overflow: operands share a sign and the result sign differs. Every
    // term is a register output, so ovf only moves on clock edges or reset.
    assign ovf = (a_p[STAGES][N-1] == b_p[STAGES][N-1])
              && (sum_p[STAGES][N-1] != a_p[STAGES][N-1]);
`endif

    // The leftover operand bits at the pipe output carry no sum information.
    logic unused_ops_s;
    assign unused_ops_s = ^{a_p[STAGES], b_p[STAGES]};

endmodule : adder_pipe_nbit

// File: tb/tb_adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_nbit
//
// Scoreboard bench. The stimulus pushes the expected result into a queue for
// each input transfer, and per-DUT monitors pop and compare on every output
// transfer. The main DUT is N=10, STAGES=2. Three companions always have
// out_ready high: STAGES=3 (chunks 4/4/2), STAGES=1, and N=1.
// Define ADDER_PIPE_OVF_EN to check ovf as well.
// -----------------------------------------------------------------------------
module tb_adder_pipe_nbit;

    localparam int N = 10;

    typedef struct {
        logic [N:0] s;
        logic       ovf;
        int         cyc;
        bit         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready;
    logic [N-1:0] a, b;
    logic         cin;
    logic         one_s = 1'b1;

    logic         in_ready, out_valid;
    logic [N:0]   sum;
    logic         in_ready3, out_valid3;
    logic [N:0]   sum3;
    logic         in_ready1, out_valid1;
    logic [N:0]   sum1;
    logic         ir_n1, ov_n1;
    logic [1:0]   sum_n1;
    logic [0:0]   a_n1, b_n1;
`ifdef ADDER_PIPE_OVF_EN
    logic         ovf, ovf3, ovf1, ovf_n1;
`endif

    assign a_n1 = a[0:0];
    assign b_n1 = b[0:0];

    exp_t exp_q[$], q3[$], q1[$], qn1[$];
    exp_t e_m, e_3, e_1, e_n;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;

    adder_pipe_nbit #(.N(N), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    adder_pipe_nbit #(.N(N), .STAGES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid3), .out_ready(one_s),
        .sum(sum3)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf3)
`endif
    );

    adder_pipe_nbit #(.N(N), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid1), .out_ready(one_s),
        .sum(sum1)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf1)
`endif
    );

    adder_pipe_nbit #(.N(1), .STAGES(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_n1),
        .a(a_n1), .b(b_n1), .cin(cin), .out_valid(ov_n1), .out_ready(one_s),
        .sum(sum_n1)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf_n1)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: output %0d with empty scoreboard (t=%0t)", name, act, $time);
    endtask

    // Main DUT monitor (latency 2 when no stall).
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) unexpected("main_extra_out", 32'(sum));
            else begin
                e_m = exp_q.pop_front();
                chk("main_sum", 32'(sum), 32'(e_m.s));
                if (e_m.lat) chk("main_latency", cyc, e_m.cyc + 2);
`ifdef ADDER_PIPE_OVF_EN
                chk("main_ovf", 32'(ovf), 32'(e_m.ovf));
`endif
            end
        end
    end

    // STAGES=3 monitor.
    always @(negedge clk) begin
        if (rst_n && out_valid3) begin
            if (q3.size() == 0) unexpected("s3_extra_out", 32'(sum3));
            else begin
                e_3 = q3.pop_front();
                chk("s3_sum", 32'(sum3), 32'(e_3.s));
                chk("s3_latency", cyc, e_3.cyc + 3);
`ifdef ADDER_PIPE_OVF_EN
                chk("s3_ovf", 32'(ovf3), 32'(e_3.ovf));
`endif
            end
        end
    end

    // STAGES=1 monitor.
    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (q1.size() == 0) unexpected("s1_extra_out", 32'(sum1));
            else begin
                e_1 = q1.pop_front();
                chk("s1_sum", 32'(sum1), 32'(e_1.s));
                chk("s1_latency", cyc, e_1.cyc + 1);
`ifdef ADDER_PIPE_OVF_EN
                chk("s1_ovf", 32'(ovf1), 32'(e_1.ovf));
`endif
            end
        end
    end

    // N=1 monitor.
    always @(negedge clk) begin
        if (rst_n && ov_n1) begin
            if (qn1.size() == 0) unexpected("n1_extra_out", 32'(sum_n1));
            else begin
                e_n = qn1.pop_front();
                chk("n1_sum", 32'(sum_n1), 32'(e_n.s));
                chk("n1_latency", cyc, e_n.cyc + 1);
`ifdef ADDER_PIPE_OVF_EN
                chk("n1_ovf", 32'(ovf_n1), 32'(e_n.ovf));
`endif
            end
        end
    end

    // A stalled output must hold value and valid until it is taken.
    logic [N:0] prev_sum;
    bit         prev_hold = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prev_hold) begin
            chk("stall_valid_held", 32'(out_valid), 32'd1);
            chk("stall_sum_held", 32'(sum), 32'(prev_sum));
        end
        prev_hold = rst_n && out_valid && !out_ready;
        prev_sum  = sum;
    end

    // Offer one vector until the main DUT takes it. Companions take it on every
    // cycle it is offered (their out_ready is high), so each offer counts.
    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                        input logic [N:0] ve, input logic vo);
        exp_t e, en;
        logic [1:0] s1b;
        bit done = 1'b0;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        e.s = ve; e.ovf = vo; e.lat = lat_chk;
        s1b = {1'b0, va[0]} + {1'b0, vb[0]} + {1'b0, vc};
        en.s = 11'(s1b); en.ovf = (va[0] == vb[0]) && (s1b[0] != va[0]); en.lat = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            e.cyc = cyc; en.cyc = cyc;
            if (in_ready3) q3.push_back(e);
            if (in_ready1) q1.push_back(e);
            if (ir_n1) qn1.push_back(en);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: in_ready stayed 0 for a=%0d b=%0d", va, vb);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_rand();
        logic [N-1:0] va, vb;
        logic         vc;
        logic [N:0]   ve;
        va = N'($urandom_range(0, 1023));
        vb = N'($urandom_range(0, 1023));
        vc = 1'($urandom_range(0, 1));
        ve = {1'b0, va} + {1'b0, vb} + {{N{1'b0}}, vc};
        send(va, vb, vc, ve, (va[N-1] == vb[N-1]) && (ve[N-1] != va[N-1]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single adds, carry corners, overflow corners.
        send(10'd7, 10'd7, 1'b0, 11'd14, 1'b0);
        idle(4);
        send(10'd1023, 10'd1023, 1'b1, 11'd2047, 1'b0);
        send(10'd511, 10'd0, 1'b1, 11'd512, 1'b1);
        send(10'd511, 10'd1, 1'b0, 11'd512, 1'b1);
        send(10'd1023, 10'd1, 1'b0, 11'd1024, 1'b0);
        idle(4);

        // Back-to-back stream.
        send(10'd33, 10'd66, 1'b0, 11'd99, 1'b0);
        send(10'd100, 10'd47, 1'b0, 11'd147, 1'b0);
        send(10'd0, 10'd0, 1'b0, 11'd0, 1'b0);
        send(10'd1023, 10'd1, 1'b0, 11'd1024, 1'b0);
        idle(4);

        // Backpressure: consumer stalls for five cycles while inputs are offered.
        lat_chk = 1'b0;
        fork
            begin
                send(10'd5, 10'd6, 1'b1, 11'd12, 1'b0);
                send(10'd200, 10'd300, 1'b0, 11'd500, 1'b0);
                send(10'd1000, 10'd24, 1'b0, 11'd1024, 1'b0);
                send(10'd512, 10'd512, 1'b1, 11'd1025, 1'b1);
            end
            begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                end
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                repeat (2) begin
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(6);
        lat_chk = 1'b1;

        // Reset with two transactions in flight.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send(10'd300, 10'd400, 1'b0, 11'd700, 1'b1);
        send(10'd12, 10'd34, 1'b1, 11'd47, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete(); q3.delete(); q1.delete(); qn1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_reset_quiet", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Random operands against the bench model.
        for (int i = 0; i < 24; i++) send_rand();
        idle(8);

        chk("drain_main", exp_q.size(), 32'd0);
        chk("drain_s3", q3.size(), 32'd0);
        chk("drain_s1", q1.size(), 32'd0);
        chk("drain_n1", qn1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_adder_pipe_nbit
